// File: rtl/forwarding_scoreboard_if.sv
// ID-stage <-> forwarding/interlock bundle: instruction fields, long-unit completion, select/stall results.
// Latency: none of its own; a plain grouping of wires.
// Backpressure: stall travels back to ID; no other flow control on this bundle.
interface forwarding_scoreboard_if #(
    parameter int NUM_READ   = 2,
    parameter int NUM_STAGES = 3
);
    localparam int SW = $clog2(NUM_STAGES + 1);

    logic                     hold;
    logic                     flush;
    logic                     id_valid;
    logic [4:0]               id_rd;
    logic                     id_we;
    logic [SW-1:0]            id_avail;
    logic                     id_long;
    logic [NUM_READ*5-1:0]    id_rs;
    logic [NUM_READ-1:0]      id_rs_used;
    logic                     long_done;
    logic [4:0]               long_rd;
    logic [NUM_READ*SW-1:0]   forward_sel;
    logic                     stall;
    logic                     busy;

    // ID stage / pipeline control side
    modport master (
        output hold, flush, id_valid, id_rd, id_we, id_avail, id_long,
               id_rs, id_rs_used, long_done, long_rd,
        input  forward_sel, stall, busy
    );

    // Scoreboard side
    modport slave (
        input  hold, flush, id_valid, id_rd, id_we, id_avail, id_long,
               id_rs, id_rs_used, long_done, long_rd,
        output forward_sel, stall, busy
    );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Forwarding select + RAW/WAW interlock: shadows in-flight destinations per stage and tracks long-op pending regs.
// Latency: forward_sel/stall/busy are combinational from registered state and current ID inputs (0 cycles).
// Backpressure: raises stall to hold ID; hold freezes the shadow stages, flush kills ID and stage 1.
module forwarding_scoreboard #(
    parameter int NUM_READ   = 2,
    parameter int NUM_STAGES = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    forwarding_scoreboard_if.slave bus
);
    localparam int SW = $clog2(NUM_STAGES + 1);

    // Stage shadow: index 0 is stage 1 (EX), index NUM_STAGES-1 is the last stage (WB).
    logic [NUM_STAGES-1:0]         stg_vld_q,   stg_vld_d;
    logic [NUM_STAGES-1:0]         stg_we_q,    stg_we_d;
    logic [NUM_STAGES-1:0][4:0]    stg_rd_q,    stg_rd_d;
    logic [NUM_STAGES-1:0][SW-1:0] stg_avail_q, stg_avail_d;
    logic [31:0]                   pend_q,      pend_d;

    logic [NUM_READ*SW-1:0]        sel_c;
    logic                          haz_c;
    logic                          stall_c;
    logic                          accept_c;

    // Per-port youngest-producer lookup plus RAW/WAW hazard detection.
    always_comb begin
        sel_c = '0;
        haz_c = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            logic [4:0] rs;
            logic       found;
            rs    = bus.id_rs[i*5 +: 5];
            found = 1'b0;
            if (bus.id_valid && bus.id_rs_used[i] && (rs != 5'd0)) begin
                if (pend_q[rs]) begin
                    // Long-op result not yet in the register file; it never appears in the stages.
                    haz_c = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        if (!found && stg_vld_q[k] && stg_we_q[k] && (stg_rd_q[k] == rs)) begin
                            found = 1'b1;
                            if (SW'(k + 1) >= stg_avail_q[k]) begin
                                sel_c[i*SW +: SW] = SW'(k + 1);
                            end else begin
                                // Youngest producer has not produced yet (e.g. load-use).
                                haz_c = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        if (bus.id_valid && bus.id_we && pend_q[bus.id_rd]) begin
            haz_c = 1'b1;
        end
    end

    assign stall_c  = bus.id_valid & haz_c;
    assign accept_c = bus.id_valid & ~stall_c & ~bus.flush & ~bus.hold;

    // Outputs are forced quiet while reset is held.
    assign bus.forward_sel = reset ? '0 : sel_c;
    assign bus.stall       = stall_c & ~reset;
    assign bus.busy        = ~reset & (|pend_q[31:1]);

    // Next-state: shift stages unless held, load stage 1 on accept, maintain the pending set.
    always_comb begin
        stg_vld_d   = stg_vld_q;
        stg_we_d    = stg_we_q;
        stg_rd_d    = stg_rd_q;
        stg_avail_d = stg_avail_q;
        pend_d      = pend_q;

        // Completion clears even while held; a same-cycle set below overrides it.
        if (bus.long_done) begin
            pend_d[bus.long_rd] = 1'b0;
        end

        if (!bus.hold) begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                // On flush the instruction leaving stage 1 is killed.
                stg_vld_d[k]   = stg_vld_q[k-1] & ~(bus.flush && (k == 1));
                stg_we_d[k]    = stg_we_q[k-1];
                stg_rd_d[k]    = stg_rd_q[k-1];
                stg_avail_d[k] = stg_avail_q[k-1];
            end
            // Long ops and x0 writers never forward from the pipeline.
            stg_vld_d[0]   = accept_c;
            stg_we_d[0]    = accept_c & bus.id_we & ~bus.id_long & (bus.id_rd != 5'd0);
            stg_rd_d[0]    = bus.id_rd;
            stg_avail_d[0] = bus.id_avail;
            if (accept_c && bus.id_long && (bus.id_rd != 5'd0)) begin
                pend_d[bus.id_rd] = 1'b1;
            end
        end

        pend_d[0] = 1'b0;
    end

    // State registers with synchronous reset discarding all in-flight and pending state.
    always_ff @(posedge clock) begin
        if (reset) begin
            stg_vld_q   <= '0;
            stg_we_q    <= '0;
            stg_rd_q    <= '0;
            stg_avail_q <= '0;
            pend_q      <= '0;
        end else begin
            stg_vld_q   <= stg_vld_d;
            stg_we_q    <= stg_we_d;
            stg_rd_q    <= stg_rd_d;
            stg_avail_q <= stg_avail_d;
            pend_q      <= pend_d;
        end
    end
endmodule

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

Parametrised forwarding and interlock unit for the multi-issue-ready core pipeline. It keeps its own shadow of the destination registers in flight across NUM_STAGES post-decode stages (stage 1 = EX … stage NUM_STAGES = WB) and selects, per ID read port, the youngest forwardable producer. It also keeps a per-register pending scoreboard for long-latency units (divider, CSR/FP units), and raises a decode stall on unresolved RAW and WAW hazards.

## Interface
- NUM_READ, 2, number of ID register read ports
- NUM_STAGES, 3, forwarding source stages after ID (EX, MEM, WB)
- SW, $clog2(NUM_STAGES+1), width of one forward select / availability field (derived, not overridable)
- Clock/reset: one clock; reset is synchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- hold  in  1  freeze all stage shadow state (e.g. memory wait)
- flush  in  1  kill the ID instruction and the stage-1 instruction
- id_valid  in  1  valid instruction in ID
- id_rd  in  5  destination register
- id_we  in  1  instruction writes id_rd
- id_avail  in  SW  first stage (1..NUM_STAGES) from which its result is forwardable (ALU=1, load=2)
- id_long  in  1  result produced by a long-latency unit, not the pipeline
- id_rs  in  NUM_READ*5  source registers, port i at bits [5i+4:5i]
- id_rs_used  in  NUM_READ  port i actually read
- long_done  in  1  long-latency unit writes long_rd this cycle
- long_rd  in  5  register written by the long unit
- forward_sel  out  NUM_READ*SW  per port: 0 = register file, s = forward from stage s
- stall  out  1  ID must not advance
- busy  out  1  any scoreboard pending bit set

## Operation
- Stage entry k (1..NUM_STAGES): valid, rd, we, avail. Entries with rd=0 are stored with we=0.
- Port i lookup (only when id_valid and id_rs_used[i] and id_rs[i]≠0): scan k=1..NUM_STAGES, first entry with valid & we & rd=id_rs[i] wins. If k ≥ avail: forward_sel[i]=k. If k < avail: hazard, forward_sel[i]=0. No match: 0.
- Pending bit of id_rs[i] set: hazard, forward_sel[i]=0 (a pending register is never also matched in the stages).
- WAW: id_valid & id_we & pending[id_rd] → hazard.
- stall = OR of all hazards; forced 0 when id_valid=0.
- Accept = id_valid & !stall & !flush & !hold.
- Edge update, priority reset > hold > flush > normal:
  - normal: stages shift k→k+1 (stage NUM_STAGES retires); stage 1 loads the ID instruction on accept, else a bubble (valid=0). Long instruction loads with we=0 and sets pending[id_rd] (if id_rd≠0).
  - flush: shift as normal, but stage 2 receives a bubble (stage-1 instruction killed), stage 1 receives a bubble, no pending set.
  - hold: stages unchanged, no pending set.
  - long_done clears pending[long_rd] in every mode except reset, including during hold. Same-cycle set and clear of one register: set wins.
- busy = OR of pending[31:1]; pending[0] is never set.

## Timing
- Reset: all stages invalid, all pending bits 0; forward_sel=0, stall=0, busy=0 on the cycle after the reset edge and while reset stays high.
- forward_sel and stall are combinational from registered state and current ID inputs; there is no latency on the outputs.
- A producer with avail=a entered at edge t is forwardable from stage a in the cycle after edge t+a−1. Load-use gives exactly one stall cycle.
- pending cleared at edge t → dependent stall drops in cycle after t (result is in RF by then).
- Reset mid-operation discards all in-flight and pending state. The long unit must be reset with it.

## Test plan
- ALU chain: issue x5 (avail=1), then read x5 on three consecutive cycles → forward_sel[0]=1, 2, 3, stall=0 throughout; fourth read → 0.
- Load-use: load x6 (avail=2), next cycle read x6 on port 1 → stall=1 for one cycle, bubble enters stage 1, next cycle forward_sel[1]=2, stall=0.
- Priority/x0: x7 in stage 1 and stage 3 → sel=1. Read x0 with an x0 writer in flight → sel=0, stall=0.
- Long op: id_long x9 accepted, busy=1; read x9 stalls for 10 cycles; long_done x9 → stall=0 next cycle, sel=0, busy=0. Issuing a write to x9 while pending → stall (WAW).
- hold/flush: hold 3 cycles → sel values unchanged, long_done still clears pending. flush with producer x4 in stage 1 → next cycle no x4 match anywhere.
- Same-cycle set and clear of x9 → pending stays 1. Reset asserted with two pending bits and full stages → all outputs 0 next cycle.
